// File: rtl/except_ctrl_pkg.sv
// Shared core definitions for the commit-stage exception sequencer:
// ecode constants, sequencer states and the commit-slot bundle.
package except_ctrl_pkg;

   localparam logic [5:0] EC_INT  = 6'h00;
   localparam logic [5:0] EC_PIL  = 6'h01;
   localparam logic [5:0] EC_PIS  = 6'h02;
   localparam logic [5:0] EC_PIF  = 6'h03;
   localparam logic [5:0] EC_PME  = 6'h04;
   localparam logic [5:0] EC_PPI  = 6'h07;
   localparam logic [5:0] EC_ADEF = 6'h08;
   localparam logic [5:0] EC_ALE  = 6'h09;
   localparam logic [5:0] EC_SYS  = 6'h0B;
   localparam logic [5:0] EC_BRK  = 6'h0C;
   localparam logic [5:0] EC_INE  = 6'h0D;
   localparam logic [5:0] EC_IPE  = 6'h0E;

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      REDIRECT
   } state_t;

   typedef struct packed {
      logic        valid;
      logic        except;
      logic        ertn;
      logic [5:0]  ecode;
      logic [31:0] pc;
   } commit_slot_t;

   function automatic commit_slot_t mk_slot(
      input logic        valid,
      input logic        except,
      input logic        ertn,
      input logic [5:0]  ecode,
      input logic [31:0] pc
   );
      commit_slot_t s;
      s.valid  = valid;
      s.except = except;
      s.ertn   = ertn;
      s.ecode  = ecode;
      s.pc     = pc;
      return s;
   endfunction

endpackage

// File: rtl/except_ctrl_if.sv
// Front-end redirect handshake between the exception sequencer
// (master) and the instruction fetch unit (slave).
interface except_ctrl_if;

   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;

   modport master (
      output redirect_valid,
      output redirect_pc,
      input  redirect_ready
   );

   modport slave (
      input  redirect_valid,
      input  redirect_pc,
      output redirect_ready
   );

endinterface

// File: rtl/except_ctrl_sel.sv
// Priority picker over the two commit slots plus the interrupt:
// oldest slot first, interrupt beats slot 0, exception beats ertn.
module except_sel
   import except_ctrl_pkg::*;
#(
   parameter logic [5:0] ECODE_INT = 6'h00
) (
   input  commit_slot_t slot0,
   input  commit_slot_t slot1,
   input  logic         int_req,
   output logic         hit,
   output logic         is_ertn,
   output logic [5:0]   ecode,
   output logic [31:0]  pc
);

   // Walk the candidates oldest-first; the first match wins.
   always_comb begin
      hit     = 1'b0;
      is_ertn = 1'b0;
      ecode   = '0;
      pc      = '0;
      if (slot0.valid && int_req) begin
         hit   = 1'b1;
         ecode = ECODE_INT;
         pc    = slot0.pc;
      end else if (slot0.valid && slot0.except) begin
         hit   = 1'b1;
         ecode = slot0.ecode;
         pc    = slot0.pc;
      end else if (slot0.valid && slot0.ertn) begin
         hit     = 1'b1;
         is_ertn = 1'b1;
         pc      = slot0.pc;
      end else if (slot1.valid && slot1.except) begin
         hit   = 1'b1;
         ecode = slot1.ecode;
         pc    = slot1.pc;
      end else if (slot1.valid && slot1.ertn) begin
         hit     = 1'b1;
         is_ertn = 1'b1;
         pc      = slot1.pc;
      end
   end

endmodule

// File: rtl/except_ctrl.sv
// Commit-stage exception / ERTN sequencer: capture strobe, timed
// flush, then one redirect to EENTRY (exception) or ERA (ERTN).
module except_ctrl
   import except_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [5:0]  ECODE_INT    = 6'h00
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    commit_valid,
   input  logic [1:0]    commit_except,
   input  logic [1:0]    commit_ertn,
   input  logic [5:0]    commit_ecode0,
   input  logic [5:0]    commit_ecode1,
   input  logic [31:0]   commit_pc0,
   input  logic [31:0]   commit_pc1,
   input  logic          int_req,
   input  logic [31:0]   eentry,
   input  logic [31:0]   era,
   output logic          except_en,
   output logic [31:0]   except_PC,
   output logic [5:0]    except_ecode,
   output logic          ertn_en,
   output logic          flush,
   output logic          commit_stall,
   except_ctrl_if.master rif
);

   localparam logic [3:0] FC = 4'(FLUSH_CYCLES);

   state_t       state;
   state_t       nstate;
   logic [3:0]   cnt;
   logic [31:0]  target;
   logic         ev_ertn;
   logic         accept;
   commit_slot_t slot0;
   commit_slot_t slot1;
   logic         sel_hit;
   logic         sel_ertn;
   logic [5:0]   sel_ecode;
   logic [31:0]  sel_pc;

   assign slot0 = mk_slot(commit_valid[0], commit_except[0],
                          commit_ertn[0], commit_ecode0, commit_pc0);
   assign slot1 = mk_slot(commit_valid[1], commit_except[1],
                          commit_ertn[1], commit_ecode1, commit_pc1);

   except_sel #(
      .ECODE_INT (ECODE_INT)
   ) u_sel (
      .slot0   (slot0),
      .slot1   (slot1),
      .int_req (int_req),
      .hit     (sel_hit),
      .is_ertn (sel_ertn),
      .ecode   (sel_ecode),
      .pc      (sel_pc)
   );

   // Commit inputs only matter while idle.
   assign accept = (state == IDLE) && sel_hit;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   // Next state: idle -> flush countdown -> redirect handshake.
   always_comb begin
      nstate = state;
      case (state)
         IDLE:     if (sel_hit) nstate = FLUSH;
         FLUSH:    if (cnt <= 4'd1) nstate = REDIRECT;
         REDIRECT: if (rif.redirect_ready) nstate = IDLE;
         default:  nstate = IDLE;
      endcase
   end

   // Registered strobes, captured event data and flush counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         except_en    <= 1'b0;
         ertn_en      <= 1'b0;
         except_PC    <= '0;
         except_ecode <= '0;
         target       <= '0;
         ev_ertn      <= 1'b0;
         cnt          <= '0;
      end else begin
         except_en <= accept && !sel_ertn;
         ertn_en   <= accept && sel_ertn;
         if (accept) begin
            ev_ertn <= sel_ertn;
            cnt     <= FC;
            if (!sel_ertn) begin
               except_PC    <= sel_pc;
               except_ecode <= sel_ecode;
               target       <= eentry;
            end
         end else if (state == FLUSH && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // Outputs decoded from state; ERTN targets the live ERA value.
   always_comb begin
      flush              = (state == FLUSH);
      commit_stall       = (state != IDLE);
      rif.redirect_valid = (state == REDIRECT);
      rif.redirect_pc    = '0;
      if (state == REDIRECT)
         rif.redirect_pc = ev_ertn ? era : target;
   end

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: hand-computed expectations for
// each exception, interrupt, ERTN, back-pressure and reset case.
module tb_except_ctrl;

   logic        clk;
   logic        rst_n;
   logic [1:0]  commit_valid;
   logic [1:0]  commit_except;
   logic [1:0]  commit_ertn;
   logic [5:0]  commit_ecode0;
   logic [5:0]  commit_ecode1;
   logic [31:0] commit_pc0;
   logic [31:0] commit_pc1;
   logic        int_req;
   logic [31:0] eentry;
   logic [31:0] era;
   logic        except_en;
   logic [31:0] except_PC;
   logic [5:0]  except_ecode;
   logic        ertn_en;
   logic        flush;
   logic        commit_stall;

   int errors = 0;
   int checks = 0;

   except_ctrl_if rif ();

   except_ctrl #(
      .FLUSH_CYCLES (2),
      .ECODE_INT    (6'h00)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .commit_valid  (commit_valid),
      .commit_except (commit_except),
      .commit_ertn   (commit_ertn),
      .commit_ecode0 (commit_ecode0),
      .commit_ecode1 (commit_ecode1),
      .commit_pc0    (commit_pc0),
      .commit_pc1    (commit_pc1),
      .int_req       (int_req),
      .eentry        (eentry),
      .era           (era),
      .except_en     (except_en),
      .except_PC     (except_PC),
      .except_ecode  (except_ecode),
      .ertn_en       (ertn_en),
      .flush         (flush),
      .commit_stall  (commit_stall),
      .rif           (rif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      commit_valid  = 2'b00;
      commit_except = 2'b00;
      commit_ertn   = 2'b00;
      commit_ecode0 = 6'h00;
      commit_ecode1 = 6'h00;
      commit_pc0    = 32'h0;
      commit_pc1    = 32'h0;
      int_req       = 1'b0;
   endtask

   task automatic idle_outs(input string tag);
      chk({tag, " except_en"}, 32'(except_en), 32'd0);
      chk({tag, " ertn_en"}, 32'(ertn_en), 32'd0);
      chk({tag, " flush"}, 32'(flush), 32'd0);
      chk({tag, " stall"}, 32'(commit_stall), 32'd0);
      chk({tag, " rvalid"}, 32'(rif.redirect_valid), 32'd0);
      chk({tag, " rpc"}, rif.redirect_pc, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      clr();
      eentry = 32'h1C008000;
      era    = 32'h0;
      rif.redirect_ready = 1'b1;
      #12;
      idle_outs("rst");
      chk("rst except_PC", except_PC, 32'h0);
      chk("rst ecode", 32'(except_ecode), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // slot 0 exception
      commit_valid  = 2'b01;
      commit_except = 2'b01;
      commit_ecode0 = 6'h0B;
      commit_pc0    = 32'h1C000100;
      #1;
      chk("t1 stall@T", 32'(commit_stall), 32'd0);
      step();
      clr();
      chk("t1 except_en", 32'(except_en), 32'd1);
      chk("t1 ertn_en", 32'(ertn_en), 32'd0);
      chk("t1 except_PC", except_PC, 32'h1C000100);
      chk("t1 ecode", 32'(except_ecode), 32'h0B);
      chk("t1 flush1", 32'(flush), 32'd1);
      chk("t1 stall1", 32'(commit_stall), 32'd1);
      chk("t1 rvalid1", 32'(rif.redirect_valid), 32'd0);
      step();
      chk("t1 except_en2", 32'(except_en), 32'd0);
      chk("t1 flush2", 32'(flush), 32'd1);
      chk("t1 rvalid2", 32'(rif.redirect_valid), 32'd0);
      step();
      chk("t1 flush3", 32'(flush), 32'd0);
      chk("t1 rvalid3", 32'(rif.redirect_valid), 32'd1);
      chk("t1 rpc3", rif.redirect_pc, 32'h1C008000);
      step();
      idle_outs("t1 done");
      chk("t1 PC hold", except_PC, 32'h1C000100);

      // slot 0 normal, slot 1 exception; held through the sequence
      commit_valid  = 2'b11;
      commit_except = 2'b10;
      commit_ecode1 = 6'h0D;
      commit_pc0    = 32'h1C000200;
      commit_pc1    = 32'h1C000204;
      #1;
      chk("t2 stall@T", 32'(commit_stall), 32'd0);
      step();
      chk("t2 except_en", 32'(except_en), 32'd1);
      chk("t2 except_PC", except_PC, 32'h1C000204);
      chk("t2 ecode", 32'(except_ecode), 32'h0D);
      chk("t2 stall1", 32'(commit_stall), 32'd1);
      step();
      chk("t2 ignored2", 32'(except_en), 32'd0);
      step();
      chk("t2 ignored3", 32'(except_en), 32'd0);
      chk("t2 rvalid3", 32'(rif.redirect_valid), 32'd1);
      clr();
      step();
      idle_outs("t2 done");

      // interrupt beats a slot 1 exception
      int_req       = 1'b1;
      commit_valid  = 2'b11;
      commit_except = 2'b10;
      commit_ecode1 = 6'h0D;
      commit_pc0    = 32'h1C000300;
      commit_pc1    = 32'h1C000304;
      step();
      clr();
      chk("t3 except_en", 32'(except_en), 32'd1);
      chk("t3 ecode", 32'(except_ecode), 32'h00);
      chk("t3 except_PC", except_PC, 32'h1C000300);
      step();
      step();
      chk("t3 rpc", rif.redirect_pc, 32'h1C008000);
      step();
      idle_outs("t3 done");

      // ertn on slot 0
      era           = 32'h1C000010;
      commit_valid  = 2'b01;
      commit_ertn   = 2'b01;
      commit_pc0    = 32'h1C000400;
      step();
      clr();
      chk("t4 ertn_en", 32'(ertn_en), 32'd1);
      chk("t4 except_en", 32'(except_en), 32'd0);
      chk("t4 flush1", 32'(flush), 32'd1);
      step();
      chk("t4 ertn_en2", 32'(ertn_en), 32'd0);
      step();
      chk("t4 rvalid", 32'(rif.redirect_valid), 32'd1);
      chk("t4 rpc", rif.redirect_pc, 32'h1C000010);
      step();
      idle_outs("t4 done");

      // back-pressure on redirect, eentry changes after capture
      rif.redirect_ready = 1'b0;
      commit_valid  = 2'b01;
      commit_except = 2'b01;
      commit_ecode0 = 6'h09;
      commit_pc0    = 32'h1C000500;
      step();
      clr();
      eentry = 32'hDEAD0000;
      chk("t5 except_en", 32'(except_en), 32'd1);
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         chk("t5 hold rvalid", 32'(rif.redirect_valid), 32'd1);
         chk("t5 hold rpc", rif.redirect_pc, 32'h1C008000);
         chk("t5 hold stall", 32'(commit_stall), 32'd1);
         step();
      end
      chk("t5 still rvalid", 32'(rif.redirect_valid), 32'd1);
      rif.redirect_ready = 1'b1;
      step();
      idle_outs("t5 done");
      eentry        = 32'h1C009000;
      commit_valid  = 2'b10;
      commit_except = 2'b10;
      commit_ecode1 = 6'h0C;
      commit_pc1    = 32'h1C000600;
      step();
      clr();
      chk("t5 new except_en", 32'(except_en), 32'd1);
      chk("t5 new PC", except_PC, 32'h1C000600);
      chk("t5 new ecode", 32'(except_ecode), 32'h0C);
      step();
      step();
      chk("t5 new rpc", rif.redirect_pc, 32'h1C009000);
      step();

      // async reset in the middle of a sequence
      commit_valid  = 2'b01;
      commit_except = 2'b01;
      commit_ecode0 = 6'h0D;
      commit_pc0    = 32'h1C000700;
      step();
      clr();
      chk("t6 pre except_en", 32'(except_en), 32'd1);
      chk("t6 pre flush", 32'(flush), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      idle_outs("t6 rst");
      chk("t6 rst PC", except_PC, 32'h0);
      chk("t6 rst ecode", 32'(except_ecode), 32'h0);
      step();
      step();
      idle_outs("t6 held");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      idle_outs("t6 post");
      eentry        = 32'h1C00A000;
      commit_valid  = 2'b01;
      commit_except = 2'b01;
      commit_ecode0 = 6'h08;
      commit_pc0    = 32'h1C000800;
      step();
      clr();
      chk("t6 except_en", 32'(except_en), 32'd1);
      chk("t6 PC", except_PC, 32'h1C000800);
      chk("t6 ecode", 32'(except_ecode), 32'h08);
      step();
      chk("t6 flush2", 32'(flush), 32'd1);
      step();
      chk("t6 rvalid", 32'(rif.redirect_valid), 32'd1);
      chk("t6 rpc", rif.redirect_pc, 32'h1C00A000);
      step();
      idle_outs("t6 done");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
